regfile: RTL and testbench

Parametrised register file replacing the single enable-gated 9-bit register in the cute_processor datapath. It holds DEPTH signed words of WIDTH bits and provides one write port, two asynchronous read ports with optional write-to-read bypass, and a per-register pending (scoreboard) bit. It sits between decode (read addresses, busy checks, busy marking) and write-back (write port).

---
 rtl/regfile.sv | 75 +++++++
 tb/tb_regfile.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: DEPTH x WIDTH signed register file, one write port, two async read
// ports with optional write forwarding, and a pending bit per register.
module regfile #(
    parameter int WIDTH    = 9,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]           rd_addr_a,
    output logic signed [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]           rd_addr_b,
    output logic signed [WIDTH-1:0] rd_data_b,
    input  logic                    busy_set,
    input  logic [AW-1:0]           busy_addr,
    output logic                    busy_a,
    output logic                    busy_b
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             hit_a, hit_b;

    // An address is usable if it names a real register that is not the hardwired zero
    function automatic logic ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_REG && a == '0);
    endfunction

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && ok(wr_addr) && wr_addr == AW'(i)) begin
                mem_d[i]  = wr_data;
                busy_d[i] = 1'b0;
            end
            // A newly issued producer outranks the one retiring this cycle
            if (busy_set && ok(busy_addr) && busy_addr == AW'(i))
                busy_d[i] = 1'b1;
            if (clr) begin
                mem_d[i]  = '0;
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // Forwarding is suppressed during reset so every read is 0 while rst_n is low
    always_comb begin
        hit_a     = BYPASS && rst_n && wr_en && ok(rd_addr_a) && wr_addr == rd_addr_a;
        hit_b     = BYPASS && rst_n && wr_en && ok(rd_addr_b) && wr_addr == rd_addr_b;
        rd_data_a = !ok(rd_addr_a) ? '0 : hit_a ? wr_data : mem_q[rd_addr_a];
        rd_data_b = !ok(rd_addr_b) ? '0 : hit_b ? wr_data : mem_q[rd_addr_b];
        busy_a    = ok(rd_addr_a) && !hit_a && busy_q[rd_addr_a];
        busy_b    = ok(rd_addr_b) && !hit_b && busy_q[rd_addr_b];
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: three parameter variants driven in parallel, checked via an expectation queue.
module tb_regfile;

    logic       clk = 1'b0;
    logic       rst_n, clr, wr_en, busy_set;
    logic [2:0] wr_addr, rd_addr_a, rd_addr_b, busy_addr;
    logic [8:0] wr_data;
    logic [8:0] rda [3];
    logic [8:0] rdb [3];
    logic       ba [3];
    logic       bb [3];

    typedef struct {
        int         sel;
        logic [8:0] val;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // u0: BYPASS=0; u1: BYPASS=1, ZERO_REG=1; u2: BYPASS=1, DEPTH=6
    regfile #(.WIDTH(9), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]),
        .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]), .busy_set(busy_set),
        .busy_addr(busy_addr), .busy_a(ba[0]), .busy_b(bb[0]));
    regfile #(.WIDTH(9), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]),
        .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]), .busy_set(busy_set),
        .busy_addr(busy_addr), .busy_a(ba[1]), .busy_b(bb[1]));
    regfile #(.WIDTH(9), .DEPTH(6), .ZERO_REG(1'b0), .BYPASS(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda[2]),
        .rd_addr_b(rd_addr_b), .rd_data_b(rdb[2]), .busy_set(busy_set),
        .busy_addr(busy_addr), .busy_a(ba[2]), .busy_b(bb[2]));

    function automatic logic [8:0] obs(input int sel);
        int i = sel / 4;
        case (sel % 4)
            0:       return rda[i];
            1:       return rdb[i];
            2:       return {8'd0, ba[i]};
            default: return {8'd0, bb[i]};
        endcase
    endfunction

    // k: 0 rd_data_a, 1 rd_data_b, 2 busy_a, 3 busy_b
    task automatic exp(input int i, input int k, input logic [8:0] v, input string tag);
        exp_t e;
        e.sel = i * 4 + k;
        e.val = v;
        e.tag = $sformatf("%s/u%0d.%0d", tag, i, k);
        q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [8:0] o;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.sel);
            n_cmp++;
            assert (o === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; busy_set = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; idle();
        wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0; busy_addr = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // write -5 to reg 3
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 9'h1FB; rd_addr_a = 3'd3; rd_addr_b = 3'd2;
        exp(0, 0, 9'h000, "wr_cycle_nobyp");
        exp(0, 1, 9'h000, "wr_cycle_b");
        exp(1, 0, 9'h1FB, "wr_cycle_byp");
        exp(2, 0, 9'h1FB, "wr_cycle_byp");
        check();
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            exp(i, 0, 9'h1FB, "readback");
            exp(i, 1, 9'h000, "reg2_untouched");
        end
        check();

        // reset pulse mid-cycle with a write and mark in flight
        #2;
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 9'h123; rd_addr_b = 3'd6;
        busy_set = 1'b1; busy_addr = 3'd3;
        for (int i = 0; i < 3; i++) begin
            exp(i, 0, 9'h000, "rst_immediate");
            exp(i, 2, 9'h000, "rst_busy");
        end
        exp(0, 1, 9'h000, "rst_wr_ignored");
        exp(1, 1, 9'h000, "rst_no_fwd");
        check();
        tick();
        exp(0, 1, 9'h000, "rst_held_wr");
        exp(0, 2, 9'h000, "rst_held_mark");
        check();
        rst_n = 1'b1; idle();
        tick();
        for (int i = 0; i < 3; i++) begin
            exp(i, 0, 9'h000, "post_rst_a");
            exp(i, 1, 9'h000, "post_rst_b");
            exp(i, 2, 9'h000, "post_rst_busy");
        end
        check();

        // mark reg 4, then write 0A7 to it
        busy_set = 1'b1; busy_addr = 3'd4; rd_addr_a = 3'd4;
        for (int i = 0; i < 3; i++) exp(i, 2, 9'h000, "mark_same_cycle");
        check();
        tick(); idle();
        for (int i = 0; i < 3; i++) exp(i, 2, 9'h001, "mark_visible");
        check();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 9'h0A7;
        exp(0, 0, 9'h000, "byp_off_data");
        exp(0, 2, 9'h001, "byp_off_busy");
        exp(1, 0, 9'h0A7, "byp_data");
        exp(1, 2, 9'h000, "byp_busy");
        exp(2, 0, 9'h0A7, "byp_data");
        exp(2, 2, 9'h000, "byp_busy");
        check();
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            exp(i, 0, 9'h0A7, "after_wr_data");
            exp(i, 2, 9'h000, "after_wr_busy");
        end
        check();

        // simultaneous mark and write on reg 5
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 9'h055; busy_set = 1'b1; busy_addr = 3'd5;
        rd_addr_b = 3'd5;
        exp(1, 1, 9'h055, "setwr_fwd");
        exp(1, 3, 9'h000, "setwr_busy_now");
        exp(0, 3, 9'h000, "setwr_busy_now");
        check();
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            exp(i, 1, 9'h055, "setwr_data");
            exp(i, 3, 9'h001, "setwr_busy");
        end
        check();

        // write and mark on reg 0
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 9'h1FF; busy_set = 1'b1; busy_addr = 3'd0;
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        exp(1, 0, 9'h000, "zr_fwd_a");
        exp(1, 1, 9'h000, "zr_fwd_b");
        exp(2, 0, 9'h1FF, "r0_fwd");
        check();
        tick(); idle();
        for (int k = 0; k < 4; k++) exp(1, k, 9'h000, "zero_reg");
        exp(0, 0, 9'h1FF, "r0_data");
        exp(0, 2, 9'h001, "r0_busy");
        exp(2, 1, 9'h1FF, "r0_data");
        exp(2, 3, 9'h001, "r0_busy");
        check();

        // invalid address 7 on DEPTH=6
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 9'h0AA; busy_set = 1'b1; busy_addr = 3'd7;
        rd_addr_a = 3'd7;
        exp(2, 0, 9'h000, "inv_fwd");
        exp(1, 0, 9'h0AA, "r7_fwd");
        check();
        tick(); idle();
        exp(2, 0, 9'h000, "inv_data");
        exp(2, 2, 9'h000, "inv_busy");
        exp(0, 0, 9'h0AA, "r7_data");
        exp(0, 2, 9'h001, "r7_busy");
        check();

        // clr against a write and a mark
        clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 9'h111;
        busy_set = 1'b1; busy_addr = 3'd2;
        tick(); idle();
        for (int a = 0; a < 8; a++) begin
            rd_addr_a = 3'(a); rd_addr_b = 3'(7 - a);
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 4; k++) exp(i, k, 9'h000, $sformatf("clr_r%0d", a));
            check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
